// File: rtl/jtag_axi_tap_seq.sv
// Master-side TMS/TDI sequencer for a JTAG TAP: runs IR/DR scans, TAP resets and idle runs from a command channel.
// Optional JTAG_AXI_TAP_SEQ_IDLE_EN adds IDLE_CYCLES Run-Test/Idle cycles after every IR/DR scan.
module jtag_axi_tap_seq #(
    parameter int MAX_LEN     = 64,
    parameter int LEN_W       = $clog2(MAX_LEN + 1),
    parameter int IDLE_CYCLES = 4
) (
    input  logic               tck,
    input  logic               trst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               busy
);

    typedef enum logic [2:0] {RST_SEQ, IDLE, PRE, SHIFT, POST, WAIT, RSP} state_t;

    localparam logic [1:0] OP_IR  = 2'b00;
    localparam logic [1:0] OP_RST = 2'b10;

    state_t             state, state_n;
    logic [LEN_W-1:0]   cnt, cnt_n;
    logic [LEN_W-1:0]   len_q, wait_len;
    logic [MAX_LEN-1:0] data_q, data_sh;
    logic [1:0]         op_q;
    logic               tms_n, tdi_n;
    logic               cmd_hs, rsp_hs, len_bad;

    // Both channels transfer on a rising tck where valid && ready; a valid side holds its payload until then.
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RSP);
    assign busy      = (state != IDLE);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign len_bad   = !cmd_op[1] && ((cmd_len == '0) || (int'(cmd_len) > MAX_LEN));
    assign data_sh   = data_q >> cnt_n;

    // state/cnt name the cycle currently on the pins, so tms/tdi are registered from the next-cycle decode
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state    <= RST_SEQ;
            cnt      <= '0;
            tms      <= 1'b1;
            tdi      <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            op_q     <= OP_IR;
            len_q    <= '0;
            wait_len <= '0;
            data_q   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            tms   <= tms_n;
            tdi   <= tdi_n;
            if (cmd_hs) begin
                op_q     <= cmd_op;
                len_q    <= cmd_len;
                data_q   <= cmd_data;
                wait_len <= cmd_op[1] ? cmd_len : LEN_W'(IDLE_CYCLES);
                rsp_data <= '0;
                rsp_err  <= len_bad;
            end else if (state == SHIFT) begin
                rsp_data <= rsp_data | (MAX_LEN'(tdo) << cnt);
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            RST_SEQ: begin
                if (cnt == LEN_W'(5)) begin
                    state_n = (op_q == OP_RST) ? RSP : IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + LEN_W'(1);
                end
            end
            IDLE: begin
                if (cmd_hs) begin
                    cnt_n = '0;
                    if (!cmd_op[1])
                        state_n = len_bad ? RSP : PRE;
                    else if (cmd_op == OP_RST)
                        state_n = RST_SEQ;
                    else
                        state_n = (cmd_len == '0) ? RSP : WAIT;
                end
            end
            PRE: begin
                if (cnt == ((op_q == OP_IR) ? LEN_W'(3) : LEN_W'(2))) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + LEN_W'(1);
                end
            end
            SHIFT: begin
                if (cnt == len_q - LEN_W'(1)) begin
                    state_n = POST;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + LEN_W'(1);
                end
            end
            POST: begin
                if (cnt == LEN_W'(1)) begin
`ifdef JTAG_AXI_TAP_SEQ_IDLE_EN
                    state_n = (IDLE_CYCLES > 0) ? WAIT : RSP;
`else
                    state_n = RSP;
`endif
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + LEN_W'(1);
                end
            end
            WAIT: begin
                if (cnt == wait_len - LEN_W'(1)) begin
                    state_n = RSP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + LEN_W'(1);
                end
            end
            RSP: begin
                if (rsp_hs)
                    state_n = IDLE;
            end
            default: begin
                state_n = RST_SEQ;
                cnt_n   = '0;
            end
        endcase
    end

    // PRE: Select-DR(1), [Select-IR(1)], Capture(0), to Shift(0); POST: Update(1), Run-Test/Idle(0)
    always_comb begin
        tms_n = 1'b0;
        tdi_n = 1'b0;
        case (state_n)
            RST_SEQ: tms_n = (cnt_n != LEN_W'(5));
            PRE:     tms_n = (cnt_n == '0) || ((op_q == OP_IR) && (cnt_n == LEN_W'(1)));
            SHIFT: begin
                tms_n = (cnt_n == len_q - LEN_W'(1));
                tdi_n = data_sh[0];
            end
            POST:    tms_n = (cnt_n == '0);
            default: tms_n = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_jtag_axi_tap_seq.sv
// Bench for jtag_axi_tap_seq: a reference TAP (4-bit IR, DR loops tdi to tdo) checks scan vectors and reset corners.
module tb_jtag_axi_tap_seq;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
`ifdef JTAG_AXI_TAP_SEQ_IDLE_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif

    logic               tck, trst;
    logic               cmd_valid, cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid, rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err, tms, tdi, tdo, busy;

    int checks = 0;
    int errors = 0;

    jtag_axi_tap_seq #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .IDLE_CYCLES(4)) dut (
        .tck(tck), .trst(trst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
    );

    // clock / reset
    initial tck = 1'b0;
    always #5 tck = ~tck;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference TAP model
    typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
                              SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR} tap_t;
    tap_t       tap;
    logic [3:0] ir_sr, ir;

    always @(posedge tck or posedge trst) begin
        if (trst) begin
            tap   <= TLR;
            ir_sr <= 4'h0;
            ir    <= 4'hF;
        end else begin
            case (tap)
                TLR:     tap <= tms ? TLR : RTI;
                RTI:     tap <= tms ? SEL_DR : RTI;
                SEL_DR:  tap <= tms ? SEL_IR : CAP_DR;
                CAP_DR:  tap <= tms ? EX1_DR : SH_DR;
                SH_DR:   tap <= tms ? EX1_DR : SH_DR;
                EX1_DR:  tap <= tms ? UPD_DR : PA_DR;
                PA_DR:   tap <= tms ? EX2_DR : PA_DR;
                EX2_DR:  tap <= tms ? UPD_DR : SH_DR;
                UPD_DR:  tap <= tms ? SEL_DR : RTI;
                SEL_IR:  tap <= tms ? TLR : CAP_IR;
                CAP_IR:  tap <= tms ? EX1_IR : SH_IR;
                SH_IR:   tap <= tms ? EX1_IR : SH_IR;
                EX1_IR:  tap <= tms ? UPD_IR : PA_IR;
                PA_IR:   tap <= tms ? EX2_IR : PA_IR;
                EX2_IR:  tap <= tms ? UPD_IR : SH_IR;
                default: tap <= tms ? SEL_DR : RTI;
            endcase
            if (tap == CAP_IR) ir_sr <= 4'b0001;
            if (tap == SH_IR)  ir_sr <= {tdi, ir_sr[3:1]};
            if (tap == UPD_IR) ir    <= ir_sr;
        end
    end

    assign tdo = (tap == SH_IR) ? ir_sr[0] : (tap == SH_DR) ? tdi : 1'b0;

    // scoreboard compare
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " tms"},       128'(tms),       128'(1));
        chk({tag, " tdi"},       128'(tdi),       128'(0));
        chk({tag, " cmd_ready"}, 128'(cmd_ready), 128'(0));
        chk({tag, " rsp_valid"}, 128'(rsp_valid), 128'(0));
        chk({tag, " rsp_err"},   128'(rsp_err),   128'(0));
        chk({tag, " rsp_data"},  128'(rsp_data),  128'(0));
        chk({tag, " busy"},      128'(busy),      128'(1));
    endtask

    // caller has just released trst on a falling edge
    task automatic reset_seq_check(input string tag);
        logic [6:0] tv, bv, rv;
        logic       anyv;
        anyv = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge tck);
            else #1;
            tv[k] = tms;
            bv[k] = busy;
            rv[k] = cmd_ready;
            anyv  = anyv | rsp_valid;
        end
        chk({tag, " seq tms"},       128'(tv),   128'h1F);
        chk({tag, " seq busy"},      128'(bv),   128'h3F);
        chk({tag, " seq cmd_ready"}, 128'(rv),   128'h40);
        chk({tag, " seq rsp_valid"}, 128'(anyv), 128'(0));
        chk({tag, " seq tap RTI"},   128'(tap == RTI), 128'(1));
    endtask

    // driver: issue one command, scramble inputs after the handshake, record tms/tdi until rsp_valid
    task automatic run_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len, input logic [63:0] data,
                           output int cyc, output logic [127:0] tms_v, output logic [127:0] tdi_v);
        int n;
        @(negedge tck);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge tck);
            n++;
        end
        chk("cmd_ready before issue", 128'(cmd_ready), 128'(1));
        @(posedge tck);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = LEN_W'($urandom);
        cmd_data  = {$urandom, $urandom};
        tms_v = '0;
        tdi_v = '0;
        cyc   = 0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge tck);
            if (rsp_valid) begin
                cyc = k;
                break;
            end
            tms_v[k-1] = tms;
            tdi_v[k-1] = tdi;
        end
    endtask

    task automatic accept_rsp();
        @(negedge tck);
        rsp_ready = 1'b1;
        @(posedge tck);
        #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        string            name;
        logic [1:0]       op;
        logic [LEN_W-1:0] len;
        logic [63:0]      data;
        logic [63:0]      exp_data;
        logic             exp_err;
        int               exp_cyc;
        logic [127:0]     exp_tms;
        logic [127:0]     exp_tdi;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int           cyc;
        logic [127:0] tv, dv;
        logic [63:0]  held;

        vecs[0] = '{"ir4 0x3",   2'b00, LEN_W'(4),  64'h3,  64'h1,  1'b0, 11 + EXTRA, 128'h183, 128'h30};
        vecs[1] = '{"dr8 0xA5",  2'b01, LEN_W'(8),  64'hA5, 64'hA5, 1'b0, 14 + EXTRA, 128'hC01, 128'h528};
        vecs[2] = '{"dr len0",   2'b01, LEN_W'(0),  64'hFF, 64'h0,  1'b1, 1, 128'h0, 128'h0};
        vecs[3] = '{"dr len65",  2'b01, LEN_W'(65), '1,     64'h0,  1'b1, 1, 128'h0, 128'h0};
        vecs[4] = '{"ir len0",   2'b00, LEN_W'(0),  64'h5,  64'h0,  1'b1, 1, 128'h0, 128'h0};
        vecs[5] = '{"idle 3",    2'b11, LEN_W'(3),  64'h0,  64'h0,  1'b0, 4, 128'h0, 128'h0};
        vecs[6] = '{"idle 0",    2'b11, LEN_W'(0),  64'h0,  64'h0,  1'b0, 1, 128'h0, 128'h0};
        vecs[7] = '{"tap reset", 2'b10, LEN_W'(9),  '1,     64'h0,  1'b0, 7, 128'h1F, 128'h0};
        vecs[8] = '{"dr1 1",     2'b01, LEN_W'(1),  64'h1,  64'h1,  1'b0, 7 + EXTRA, 128'h19, 128'h8};
        vecs[9] = '{"dr64",      2'b01, LEN_W'(64), 64'hDEADBEEF01234567, 64'hDEADBEEF01234567, 1'b0,
                    70 + EXTRA, (128'h3 << 66) | 128'h1, 128'(64'hDEADBEEF01234567) << 3};

        trst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge tck);
        chk_reset_vals("por");
        trst = 1'b0;
        reset_seq_check("por");

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].op, vecs[i].len, vecs[i].data, cyc, tv, dv);
            chk({vecs[i].name, " cycles"},   128'(cyc),         128'(vecs[i].exp_cyc));
            chk({vecs[i].name, " rsp_data"}, 128'(rsp_data),    128'(vecs[i].exp_data));
            chk({vecs[i].name, " rsp_err"},  128'(rsp_err),     128'(vecs[i].exp_err));
            chk({vecs[i].name, " tms seq"},  tv,                vecs[i].exp_tms);
            chk({vecs[i].name, " tdi seq"},  dv,                vecs[i].exp_tdi);
            chk({vecs[i].name, " tap RTI"},  128'(tap == RTI),  128'(1));
            if (i == 0) chk("ir4 model IR", 128'(ir), 128'h3);
            accept_rsp();
        end
        chk("model IR kept", 128'(ir), 128'h3);

        // response backpressure with a command waiting
        run_cmd(2'b01, LEN_W'(8), 64'h5A, cyc, tv, dv);
        chk("bp scan cycles", 128'(cyc), 128'(14 + EXTRA));
        held      = rsp_data;
        chk("bp rsp_data", 128'(held), 128'h5A);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_len   = LEN_W'(2);
        cmd_data  = '0;
        for (int i = 0; i < 10; i++) begin
            chk("bp cmd_ready",  128'(cmd_ready), 128'(0));
            chk("bp tms",        128'(tms),       128'(0));
            chk("bp rsp_valid",  128'(rsp_valid), 128'(1));
            chk("bp data held",  128'(rsp_data),  128'h5A);
            @(negedge tck);
        end
        rsp_ready = 1'b1;
        @(posedge tck);
        #1;
        rsp_ready = 1'b0;
        @(negedge tck);
        chk("bp rsp_valid cleared", 128'(rsp_valid), 128'(0));
        chk("bp next cmd_ready",    128'(cmd_ready), 128'(1));
        @(posedge tck);
        #1;
        cmd_valid = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge tck);
            if (rsp_valid) begin
                cyc = k;
                break;
            end
        end
        chk("bp idle2 cycles", 128'(cyc), 128'(3));
        accept_rsp();

        // trst during shift bit 3 of a 16-bit DR scan
        @(negedge tck);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_len   = LEN_W'(16);
        cmd_data  = 64'hFFFF;
        @(posedge tck);
        #1;
        cmd_valid = 1'b0;
        repeat (7) @(negedge tck);
        chk("mid tdi bit3",       128'(tdi),      128'(1));
        chk("mid rsp_data bits",  128'(rsp_data), 128'h7);
        trst = 1'b1;
        #1;
        chk_reset_vals("mid rst");
        @(negedge tck);
        trst = 1'b0;
        reset_seq_check("mid rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
